svc_soc_io_regbank: RTL and testbench
=====================================

// Module: svc_soc_io_regbank
// PURPOSE
//  Memory-mapped I/O register bank between the RISC-V core's I/O bus and the board peripherals.
//  Decodes CPU I/O reads/writes to an LED register, an 8-bit GPIO output register and a UART transmitter.
//  The UART transmitter is 8N1 and drives the serial pin.
//  Read timing follows the SoC memory type: combinational for SRAM builds, registered for BRAM builds.
// PARAMETERS
//  CLOCK_FREQ  100_000_000  clk frequency in Hz
//  BAUD_RATE   115_200      UART bit rate; CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer division, must be >= 2)
//  MEM_TYPE    1            MEM_TYPE_BRAM=0: registered read; MEM_TYPE_SRAM=1: combinational read
// PORTS
//  Clocking: one clock; reset is synchronous and active-high.
//  clk       in   1   system clock
//  rst       in   1   synchronous reset, active-high
//  io_wen    in   1   write enable, one transfer per cycle
//  io_waddr  in   32  write byte address; decoded by io_waddr[7:2]
//  io_wdata  in   32  write data
//  io_wstrb  in   4   byte lane enables for the write
//  io_ren    in   1   read enable; tied high by SRAM builds
//  io_raddr  in   32  read byte address; decoded by io_raddr[7:2]
//  io_rdata  out  32  read data
//  led       out  1   LED register bit 0
//  gpio      out  8   GPIO output register
//  uart_tx   out  1   serial TX pin; idle high
// BEHAVIOUR
//  Register map (offset, access, fields):
//   0x00 LED   RW  [0]=led; lane 0 writes it
//   0x04 GPIO  RW  [7:0]=gpio; lane 0 writes it
//   0x08 UTX   W   byte write with wstrb[0]=1 starts transmission of wdata[7:0]; reads as 0
//   0x0C USTAT R   [0]=tx_busy; writes ignored
//  Unmapped offsets and bits outside defined fields: read 0, writes ignored.
//  Only address bits [7:2] are decoded; upper address bits are don't-care.
//  Writes take effect on the clk edge where io_wen=1; register outputs change the following cycle.
//  Reset values: led=0, gpio=0, uart_tx=1, tx_busy=0, io_rdata=0.
//  Read path, SRAM (MEM_TYPE=1): io_rdata = f(io_raddr) combinationally; zero latency.
//  Read path, BRAM (MEM_TYPE=0): io_rdata is registered on an edge with io_ren=1; data valid the next cycle.
//   With io_ren=0, io_rdata holds its last value.
//  Simultaneous read and write to the same register: the read returns the pre-write value.
//  UART TX, 8N1, LSB first:
//   Frame: start bit 0, then d[0]..d[7], then stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
//   tx_busy=1 from the cycle after the accepting write until the last stop-bit cycle completes.
//   On the following cycle tx_busy=0 and uart_tx=1.
//   A UTX write while tx_busy=1 is dropped; the frame in progress is unaffected. Software polls USTAT.
//   A UTX write on the same edge tx_busy falls is accepted.
//   Reset mid-frame aborts the frame immediately: uart_tx=1, tx_busy=0.
//  UART TX FSM: IDLE -> START -> DATA(x8, bit index 0..7) -> STOP -> IDLE.
//   One shared baud counter runs 0..CLKS_PER_BIT-1 and advances the FSM on wrap.
// STRUCTURE
//  Shared package holds MEM_TYPE_BRAM/MEM_TYPE_SRAM, the register offsets (IO_LED, IO_GPIO, IO_UTX, IO_USTAT) and the UART FSM state enum.
//  One sub-module, svc_soc_uart_tx_8n1, with ports clk, rst, valid, data[7:0], busy, tx.
//  The top level contains decode, the registers and the read mux.
// TESTING (bench uses CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 -> 10 clks/bit)
//  1. After reset: led=0, gpio=0, uart_tx=1; reading 0x0C returns 0.
//  2. Write 0x04 data 0xA5 wstrb=4'b0001 -> gpio=0xA5. Write 0x00 data 1 -> led=1.
//     Write 0x04 data 0xFF wstrb=4'b0000 -> gpio stays 0xA5.
//  3. BRAM mode: io_ren=1 with raddr 0x04 -> io_rdata=0x000000A5 on the next cycle, held after io_ren drops.
//     SRAM mode: same read returns 0xA5 in the same cycle.
//  4. Write 0x08 data 0x55 -> uart_tx: 10 clks low, then bits 1,0,1,0,1,0,1,0 (10 clks each), then 10 clks high.
//     tx_busy=1 for exactly 100 cycles.
//  5. Second UTX write (0x41) 20 cycles into the 0x55 frame -> dropped; only 0x55 is sent.
//     A write right after busy clears -> 0x41 frame sent.
//  6. Assert rst at bit 3 of a frame -> uart_tx=1 and tx_busy=0 the next cycle; gpio=0, led=0.
//     Reads of unmapped 0x40 return 0.

Source files
------------

// File: rtl/svc_soc_io_regbank_pkg.sv
// Shared definitions for the SoC I/O register bank: memory-type selectors,
// register byte offsets and the UART transmitter state encoding.
package svc_soc_io_regbank_pkg;

  localparam int MEM_TYPE_BRAM = 0;
  localparam int MEM_TYPE_SRAM = 1;

  localparam logic [7:0] IO_LED   = 8'h00;
  localparam logic [7:0] IO_GPIO  = 8'h04;
  localparam logic [7:0] IO_UTX   = 8'h08;
  localparam logic [7:0] IO_USTAT = 8'h0C;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // Word index used by the decoder; bits [1:0] and above [7] are ignored.
  function automatic logic [5:0] reg_idx(input logic [7:0] off);
    return off[7:2];
  endfunction

endpackage

// File: rtl/svc_soc_uart_tx_8n1.sv
// 8N1 UART transmitter, LSB first; serial line is registered (one-cycle start latency).
// No backpressure: valid is accepted only when idle or in the final stop-bit cycle, otherwise dropped.
// busy stays high from the cycle after acceptance until the stop bit has fully elapsed.
module svc_soc_uart_tx_8n1
  import svc_soc_io_regbank_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          wrap;
  logic          accept;

  assign wrap   = (cnt_q == CNT_MAX);
  // Back-to-back frames: a request landing on the last stop-bit cycle is taken.
  assign accept = valid && ((state_q == UART_IDLE) || (state_q == UART_STOP && wrap));

  always_comb begin
    state_d = state_q;
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;

    case (state_q)
      UART_IDLE: begin
        cnt_d = '0;
      end
      UART_START: begin
        if (wrap) begin
          state_d = UART_DATA;
          idx_d   = 3'd0;
        end
      end
      UART_DATA: begin
        if (wrap) begin
          if (idx_q == 3'd7) begin
            state_d = UART_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      UART_STOP: begin
        if (wrap) begin
          state_d = UART_IDLE;
        end
      end
      default: begin
        state_d = UART_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (accept) begin
      state_d = UART_START;
      cnt_d   = '0;
      idx_d   = 3'd0;
      shreg_d = data;
    end

    case (state_d)
      UART_START: tx_d = 1'b0;
      UART_DATA:  tx_d = shreg_d[idx_d];
      default:    tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UART_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shreg_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  assign busy = (state_q != UART_IDLE);
  assign tx   = tx_q;

endmodule

// File: rtl/svc_soc_io_regbank.sv
// CPU I/O register bank: LED, GPIO, UART TX data and status behind a word-decoded bus.
// Writes land on the enabling edge; reads are combinational (SRAM) or one-cycle registered (BRAM).
// No backpressure: every transfer completes; UART writes while busy are silently dropped.
module svc_soc_io_regbank
  import svc_soc_io_regbank_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int MEM_TYPE   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_wen,
  input  logic [31:0] io_waddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb,
  input  logic        io_ren,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  output logic        led,
  output logic [7:0]  gpio,
  output logic        uart_tx
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;

  localparam logic [5:0] LED_IDX   = reg_idx(IO_LED);
  localparam logic [5:0] GPIO_IDX  = reg_idx(IO_GPIO);
  localparam logic [5:0] UTX_IDX   = reg_idx(IO_UTX);
  localparam logic [5:0] USTAT_IDX = reg_idx(IO_USTAT);

  logic        led_q, led_d;
  logic [7:0]  gpio_q, gpio_d;
  logic        wr_lane0;
  logic [5:0]  widx;
  logic [5:0]  ridx;
  logic        utx_vld;
  logic        tx_busy;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign wr_lane0 = io_wen && io_wstrb[0];
  assign widx     = io_waddr[7:2];
  assign ridx     = io_raddr[7:2];
  assign utx_vld  = wr_lane0 && (widx == UTX_IDX);

  always_comb begin
    led_d  = led_q;
    gpio_d = gpio_q;
    if (wr_lane0 && (widx == LED_IDX)) begin
      led_d = io_wdata[0];
    end
    if (wr_lane0 && (widx == GPIO_IDX)) begin
      gpio_d = io_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q  <= 1'b0;
      gpio_q <= 8'd0;
    end else begin
      led_q  <= led_d;
      gpio_q <= gpio_d;
    end
  end

  // Reads see pre-write state because they use the flop outputs, not the _d values.
  always_comb begin
    rd_mux = 32'd0;
    case (ridx)
      LED_IDX:   rd_mux = {31'd0, led_q};
      GPIO_IDX:  rd_mux = {24'd0, gpio_q};
      USTAT_IDX: rd_mux = {31'd0, tx_busy};
      default:   rd_mux = 32'd0;
    endcase
  end

  generate
    if (MEM_TYPE == MEM_TYPE_SRAM) begin : g_sram_rd
      assign io_rdata = rd_mux;
    end else begin : g_bram_rd
      logic [31:0] rdata_q, rdata_d;

      always_comb begin
        rdata_d = rdata_q;
        if (io_ren) begin
          rdata_d = rd_mux;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_q <= 32'd0;
        end else begin
          rdata_q <= rdata_d;
        end
      end

      assign io_rdata = rdata_q;
    end
  endgenerate

  svc_soc_uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk  (clk),
    .rst  (rst),
    .valid(utx_vld),
    .data (io_wdata[7:0]),
    .busy (tx_busy),
    .tx   (uart_tx)
  );

  assign led  = led_q;
  assign gpio = gpio_q;

  assign unused_bits = ^{io_waddr[31:8], io_waddr[1:0], io_wdata[31:8],
                         io_wstrb[3:1], io_raddr[31:8], io_raddr[1:0], io_ren};

endmodule

// File: tb/tb_svc_soc_io_regbank.sv
// Bench for the I/O register bank: SRAM- and BRAM-read instances share stimulus and are
// checked each cycle against a frame-level model plus directed literal expectations.
module tb_svc_soc_io_regbank;

  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_wen = 1'b0;
  logic [31:0] io_waddr = 32'd0;
  logic [31:0] io_wdata = 32'd0;
  logic [3:0]  io_wstrb = 4'd0;
  logic        io_ren = 1'b0;
  logic [31:0] io_raddr = 32'h0C;

  logic [31:0] rdata_s, rdata_b;
  logic        led_s, led_b, tx_s, tx_b;
  logic [7:0]  gpio_s, gpio_b;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model state
  logic        led_m = 1'b0;
  logic [7:0]  gpio_m = 8'd0;
  int          pos_m = -1;
  logic [9:0]  frame_m = 10'h3FF;
  logic [31:0] bram_m = 32'd0;

  always #5 clk = ~clk;

  svc_soc_io_regbank #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .MEM_TYPE(1)) dut_sram (
    .clk(clk), .rst(rst), .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata),
    .io_wstrb(io_wstrb), .io_ren(io_ren), .io_raddr(io_raddr), .io_rdata(rdata_s),
    .led(led_s), .gpio(gpio_s), .uart_tx(tx_s));

  svc_soc_io_regbank #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .MEM_TYPE(0)) dut_bram (
    .clk(clk), .rst(rst), .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata),
    .io_wstrb(io_wstrb), .io_ren(io_ren), .io_raddr(io_raddr), .io_rdata(rdata_b),
    .led(led_b), .gpio(gpio_b), .uart_tx(tx_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] read_model(input logic [31:0] a);
    logic [5:0] w;
    w = a[7:2];
    case (w)
      6'd0:    return {31'd0, led_m};
      6'd1:    return {24'd0, gpio_m};
      6'd3:    return {31'd0, (pos_m >= 0)};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic tx_model();
    if (pos_m < 0) return 1'b1;
    return frame_m[pos_m / CPB];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      led_m  <= 1'b0;
      gpio_m <= 8'd0;
      pos_m  <= -1;
      bram_m <= 32'd0;
    end else begin
      if (io_ren) bram_m <= read_model(io_raddr);
      if (io_wen && io_wstrb[0] && io_waddr[7:2] == 6'd0) led_m <= io_wdata[0];
      if (io_wen && io_wstrb[0] && io_waddr[7:2] == 6'd1) gpio_m <= io_wdata[7:0];
      if (io_wen && io_wstrb[0] && io_waddr[7:2] == 6'd2 && (pos_m < 0 || pos_m == FRAME - 1)) begin
        pos_m   <= 0;
        frame_m <= {1'b1, io_wdata[7:0], 1'b0};
      end else if (pos_m >= 0) begin
        pos_m <= (pos_m == FRAME - 1) ? -1 : pos_m + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_led_s",   {31'd0, led_s},  {31'd0, led_m});
      chk("m_led_b",   {31'd0, led_b},  {31'd0, led_m});
      chk("m_gpio_s",  {24'd0, gpio_s}, {24'd0, gpio_m});
      chk("m_gpio_b",  {24'd0, gpio_b}, {24'd0, gpio_m});
      chk("m_tx_s",    {31'd0, tx_s},   {31'd0, tx_model()});
      chk("m_tx_b",    {31'd0, tx_b},   {31'd0, tx_model()});
      chk("m_rdata_s", rdata_s, read_model(io_raddr));
      chk("m_rdata_b", rdata_b, bram_m);
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    io_wen   = 1'b1;
    io_waddr = a;
    io_wdata = d;
    io_wstrb = s;
    sync();
    io_wen   = 1'b0;
    io_wstrb = 4'd0;
  endtask

  // Called right after the accepting edge; samples mid-bit of start, 8 data, stop.
  task automatic capture(output logic [9:0] bits);
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? 6 : CPB) @(negedge clk);
      bits[k] = tx_s;
    end
  endtask

  task automatic wait_idle(input string nm);
    bit got;
    got = 1'b0;
    io_raddr = 32'h0C;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      if (rdata_s[0] == 1'b0) got = 1'b1;
    end
    chk(nm, {31'd0, got}, 32'd1);
    sync();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] pat;
    logic [9:0] fr;
    int busy_cnt;

    sync();
    chk_en = 1'b1;
    idle(2);
    rst = 1'b0;

    // 1. reset state
    @(negedge clk);
    chk("rst_led",   {31'd0, led_s}, 32'd0);
    chk("rst_gpio",  {24'd0, gpio_s}, 32'd0);
    chk("rst_tx",    {31'd0, tx_s}, 32'd1);
    chk("rst_ustat", rdata_s, 32'd0);
    chk("rst_rdb",   rdata_b, 32'd0);
    sync();

    // 2. register writes, lane masking, unmapped writes
    wr(32'h04, 32'hA5, 4'b0001);
    wr(32'h00, 32'h1, 4'b0001);
    wr(32'h04, 32'hFF, 4'b0000);
    wr(32'h00, 32'h0, 4'b1110);
    wr(32'h40, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    chk("gpio_a5_s", {24'd0, gpio_s}, 32'hA5);
    chk("gpio_a5_b", {24'd0, gpio_b}, 32'hA5);
    chk("led_1",     {31'd0, led_s}, 32'd1);
    sync();

    // 3. read timing
    io_ren = 1'b1;
    io_raddr = 32'h04;
    @(negedge clk);
    chk("sram_rd_same", rdata_s, 32'hA5);
    sync();
    io_ren = 1'b0;
    io_raddr = 32'h00;
    @(negedge clk);
    chk("bram_rd_next", rdata_b, 32'hA5);
    chk("sram_rd_led",  rdata_s, 32'h1);
    idle(3);
    @(negedge clk);
    chk("bram_rd_hold", rdata_b, 32'hA5);
    sync();
    io_raddr = 32'hFFFF_FF04;
    @(negedge clk);
    chk("upper_dc", rdata_s, 32'hA5);
    sync();
    io_ren = 1'b1;
    io_raddr = 32'h04;
    wr(32'h04, 32'h3C, 4'b0001);
    io_ren = 1'b0;
    @(negedge clk);
    chk("rdw_pre",  rdata_b, 32'hA5);
    chk("rdw_gpio", {24'd0, gpio_s}, 32'h3C);
    sync();

    // 4. 0x55 frame waveform and busy length
    io_raddr = 32'h0C;
    pat = {1'b1, 8'h55, 1'b0};
    busy_cnt = 0;
    wr(32'h08, 32'h55, 4'b0001);
    for (int i = 0; i < FRAME + 10; i++) begin
      @(negedge clk);
      chk("tx55", {31'd0, tx_s}, (i < FRAME) ? {31'd0, pat[i / CPB]} : 32'd1);
      if (rdata_s[0]) busy_cnt++;
    end
    chk("busy_len", busy_cnt, FRAME);
    sync();

    // 5. write while busy is dropped; write after busy clears is sent
    wr(32'h08, 32'h55, 4'b0001);
    fork
      capture(fr);
      begin
        idle(19);
        wr(32'h08, 32'h41, 4'b0001);
      end
    join
    chk("frame55", {22'd0, fr}, {22'd0, 1'b1, 8'h55, 1'b0});
    wait_idle("poll1");
    wr(32'h08, 32'h41, 4'b0001);
    capture(fr);
    chk("frame41", {22'd0, fr}, {22'd0, 1'b1, 8'h41, 1'b0});
    wait_idle("poll2");

    // write on the edge busy falls is accepted
    wr(32'h08, 32'h0F, 4'b0001);
    idle(FRAME - 1);
    wr(32'h08, 32'hF0, 4'b0001);
    capture(fr);
    chk("frame_b2b", {22'd0, fr}, {22'd0, 1'b1, 8'hF0, 1'b0});
    wait_idle("poll3");

    // 6. reset during data bit 3 of 0xC3
    wr(32'h08, 32'hC3, 4'b0001);
    idle(42);
    @(negedge clk);
    chk("bit3", {31'd0, tx_s}, 32'd0);
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_tx",   {31'd0, tx_s}, 32'd1);
    chk("rst_mid_busy", rdata_s, 32'd0);
    chk("rst_mid_gpio", {24'd0, gpio_s}, 32'd0);
    chk("rst_mid_led",  {31'd0, led_s}, 32'd0);
    sync();
    wr(32'h04, 32'h77, 4'b0001);
    io_ren = 1'b1;
    io_raddr = 32'h40;
    @(negedge clk);
    chk("unmapped_s", rdata_s, 32'd0);
    sync();
    io_ren = 1'b0;
    @(negedge clk);
    chk("unmapped_b", rdata_b, 32'd0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
